// File: rtl/down_timer_if.sv
// Control/status bundle for the loadable down-counter timer.
// The sequencer side owns the controls; the timer side owns count and flags.
interface down_timer_if #(
  parameter int width = 4
);
  logic             load;
  logic [width-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [width-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;

  modport master (
    output load, load_val, start, pause, auto_reload,
    input  count, busy, done, tc
  );

  modport slave (
    input  load, load_val, start, pause, auto_reload,
    output count, busy, done, tc
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter timer with a one-cycle terminal-count pulse,
// pause/hold, and optional auto-reload for periodic ticks.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | loaded or reset, waiting for start (count holds loaded value)
//   RUN   | decrementing one per edge; tc at the terminal edge
//   HOLD  | frozen by pause; the resume edge does not decrement
//   DONE  | period expired with auto_reload=0; count is 0
module down_timer #(
  parameter int width = 4
) (
  input  logic         clk,
  input  logic         rstn,
  down_timer_if.slave  tif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [width-1:0] zero_val = '0;
  localparam logic [width-1:0] one_val  = {{(width-1){1'b0}}, 1'b1};

  state_t           state;
  logic [width-1:0] count_q;
  logic [width-1:0] reload_q;
  logic             busy_q;
  logic             done_q;
  logic             tc_q;

  // rstn is active-high here: asserting it clears everything without a clock.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (tif.load) begin
        count_q  <= tif.load_val;
        reload_q <= tif.load_val;
        state    <= IDLE;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (tif.start && (count_q != zero_val)) begin
              state  <= RUN;
              busy_q <= 1'b1;
              done_q <= 1'b0;
            end
          end

          RUN: begin
            if (tif.pause) begin
              state <= HOLD;
            end else if (count_q > one_val) begin
              count_q <= count_q - one_val;
            end else if ((count_q == one_val) && tif.auto_reload) begin
              tc_q    <= 1'b1;
              count_q <= reload_q;
            end else begin
              // Terminal without reload; a zero count in RUN lands here too.
              tc_q    <= 1'b1;
              count_q <= '0;
              state   <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end

          HOLD: begin
            if (!tif.pause) begin
              state <= RUN;
            end
          end

          DONE: begin
            if (tif.start && (reload_q != zero_val)) begin
              count_q <= reload_q;
              state   <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end

          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign tif.count = count_q;
  assign tif.busy  = busy_q;
  assign tif.done  = done_q;
  assign tif.tc    = tc_q;

endmodule
